prf_stream_requester: RTL and testbench

//  Initiator side of the prf_evaluate start/done interface. It accepts one request
//  (nonce, start index, symbol count) and runs prf_evaluate once per symbol, with the

---
 rtl/prf_stream_requester_pkg.sv | 30 +++
 rtl/prf_stream_requester_if.sv | 41 ++++
 rtl/prf_stream_requester_packer.sv | 50 +++++
 rtl/prf_stream_requester.sv | 132 +++++++++++++
 tb/tb_prf_stream_requester.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prf_stream_requester_pkg.sv
// Shared constants and types for the PRF stream requester: PRF geometry, word packing
// geometry, timeout budget and the requester state encoding.
package prf_stream_requester_pkg;

    localparam int P       = 32;
    localparam int N       = 2048;
    localparam int N_LWR   = 445;
    localparam int OUT_W   = $clog2(P);
    localparam int WORD_W  = 64;
    localparam int SYMS    = WORD_W / OUT_W;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4096;
    localparam int NSYM_W  = 4;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [NSYM_W-1:0] SYMS_N = NSYM_W'(SYMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_e;

    // True when writing one more symbol into a buffer holding nsym symbols fills the word.
    function automatic logic fills_word(input logic [NSYM_W-1:0] nsym);
        return nsym == SYMS_N - NSYM_W'(1);
    endfunction

endpackage

// File: rtl/prf_stream_requester_if.sv
// Request, PRF start/done and packed-word stream signals of the requester.
// master = the requester itself, slave = its environment (requestor, PRF, consumer).
interface prf_stream_requester_if;
    import prf_stream_requester_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [63:0]       req_nonce;
    logic [63:0]       req_start_index;
    logic [CNT_W-1:0]  req_count;

    logic              prf_start;
    logic [63:0]       prf_nonce;
    logic [63:0]       prf_index;
    logic [OUT_W-1:0]  prf_out;
    logic              prf_done;

    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic [NSYM_W-1:0] word_nsym;
    logic              word_last;

    logic              busy;
    logic              timeout_err;

    modport master (
        input  req_valid, req_nonce, req_start_index, req_count,
        input  prf_out, prf_done, word_ready,
        output req_ready, prf_start, prf_nonce, prf_index,
        output word_valid, word_data, word_nsym, word_last, busy, timeout_err
    );

    modport slave (
        output req_valid, req_nonce, req_start_index, req_count,
        output prf_out, prf_done, word_ready,
        input  req_ready, prf_start, prf_nonce, prf_index,
        input  word_valid, word_data, word_nsym, word_last, busy, timeout_err
    );

endinterface

// File: rtl/prf_stream_requester_packer.sv
// prf_sym_packer: accumulates OUT_W-bit symbols LSB-first into a WORD_W-bit word.
// Clear has priority over write; writes beyond SYMS symbols are dropped.
module prf_sym_packer
    import prf_stream_requester_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [OUT_W-1:0]  wr_data_i,
    output logic [WORD_W-1:0] data_o,
    output logic [NSYM_W-1:0] nsym_o
);

    logic [WORD_W-1:0] data_q, data_d;
    logic [NSYM_W-1:0] nsym_q, nsym_d;

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned and no latch is inferred.
        data_d = data_q;
        nsym_d = nsym_q;
        if (clr_i) begin
            data_d = '0;
            nsym_d = '0;
        end else if (wr_en_i && (nsym_q < SYMS_N)) begin
            for (int k = 0; k < SYMS; k++) begin
                if (nsym_q == NSYM_W'(k)) begin
                    data_d[k*OUT_W +: OUT_W] = wr_data_i;
                end
            end
            nsym_d = nsym_q + NSYM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the pack buffer is reset like any control register, so unused slots and MSBs always read as zero.
        if (rst) begin
            data_q <= '0;
            nsym_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            data_q <= data_d;
            nsym_q <= nsym_d;
        end
    end

    assign data_o = data_q;
    assign nsym_o = nsym_q;

endmodule

// File: rtl/prf_stream_requester.sv
// Drives prf_evaluate once per requested symbol, packs the results into words and
// streams them out; aborts a stalled evaluation after TIMEOUT cycles in WAIT.
module prf_stream_requester
    import prf_stream_requester_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    prf_stream_requester_if.master bus
);

    state_e           state_q;
    logic [63:0]      nonce_q;
    logic [63:0]      index_q;
    logic [CNT_W-1:0] remaining_q;
    logic [TMO_W-1:0] tmo_q;
    logic             req_ready_q;
    logic             prf_start_q;
    logic             word_valid_q;
    logic             word_last_q;
    logic             busy_q;
    logic             timeout_err_q;

    logic              pk_wr_en;
    logic              pk_clr;
    logic [WORD_W-1:0] pk_data;
    logic [NSYM_W-1:0] pk_nsym;
    logic              rem_last;
    logic              word_full;

    // Done is only meaningful in WAIT; stale pulses from aborted runs fall outside it.
    assign pk_wr_en  = (state_q == WAIT) && bus.prf_done;
    assign pk_clr    = (state_q == EMIT) && bus.word_ready;
    assign rem_last  = (remaining_q == CNT_W'(1));
    assign word_full = fills_word(pk_nsym);

    prf_sym_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (pk_clr),
        .wr_en_i   (pk_wr_en),
        .wr_data_i (bus.prf_out),
        .data_o    (pk_data),
        .nsym_o    (pk_nsym)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            nonce_q       <= '0;
            index_q       <= '0;
            remaining_q   <= '0;
            tmo_q         <= '0;
            req_ready_q   <= 1'b1;
            prf_start_q   <= 1'b0;
            word_valid_q  <= 1'b0;
            word_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            prf_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        nonce_q       <= bus.req_nonce;
                        index_q       <= bus.req_start_index;
                        remaining_q   <= bus.req_count;
                        timeout_err_q <= 1'b0;
                        if (bus.req_count != '0) begin
                            state_q     <= ISSUE;
                            prf_start_q <= 1'b1;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    tmo_q   <= '0;
                end
                WAIT: begin
                    if (bus.prf_done) begin
                        index_q     <= index_q + 64'd1;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (word_full || rem_last) begin
                            state_q      <= EMIT;
                            word_valid_q <= 1'b1;
                            word_last_q  <= rem_last;
                        end else begin
                            state_q     <= ISSUE;
                            prf_start_q <= 1'b1;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // Abort: flush whatever is packed, possibly an empty word.
                        state_q       <= EMIT;
                        timeout_err_q <= 1'b1;
                        word_valid_q  <= 1'b1;
                        word_last_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                EMIT: begin
                    if (bus.word_ready) begin
                        word_valid_q <= 1'b0;
                        word_last_q  <= 1'b0;
                        if (word_last_q) begin
                            state_q     <= IDLE;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q     <= ISSUE;
                            prf_start_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.prf_start   = prf_start_q;
    assign bus.prf_nonce   = nonce_q;
    assign bus.prf_index   = index_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.word_data   = pk_data;
    assign bus.word_nsym   = pk_nsym;
    assign bus.word_last   = word_last_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prf_stream_requester.sv
// Directed bench for prf_stream_requester with a 3-cycle prf_evaluate stub and
// scoreboards for PRF calls and packed output words.
module tb_prf_stream_requester;
    import prf_stream_requester_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  nsym;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [63:0] nonce;
        logic [63:0] index;
    } call_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prf_stream_requester_if bus ();

    prf_stream_requester dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int n_starts = 0;
    int n_words  = 0;

    word_t exp_words[$];
    call_t exp_calls[$];
    word_t got_word;
    call_t got_call;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // prf_evaluate stub: symbol = index[4:0] ^ nonce[4:0], done pulse 3 cycles after start.
    logic [2:0]  start_sh   = '0;
    logic [63:0] stub_idx   = '0;
    logic [63:0] stub_nonce = '0;
    logic        stub_en;

    always @(posedge clk) begin
        start_sh <= {start_sh[1:0], bus.prf_start};
        if (bus.prf_start) begin
            stub_idx   <= bus.prf_index;
            stub_nonce <= bus.prf_nonce;
        end
    end

    assign bus.prf_done = stub_en && start_sh[2];
    assign bus.prf_out  = stub_idx[4:0] ^ stub_nonce[4:0];

    // Monitors: every PRF call and every accepted word is matched against the scoreboards.
    always @(negedge clk) begin
        if (bus.prf_start) begin
            n_starts++;
            if (exp_calls.size() == 0) begin
                check("prf_start_unexpected", bus.prf_start, 1'b0);
            end else begin
                got_call = exp_calls.pop_front();
                check("prf_index", bus.prf_index, got_call.index);
                check("prf_nonce", bus.prf_nonce, got_call.nonce);
            end
        end
        if (bus.word_valid && bus.word_ready) begin
            n_words++;
            if (exp_words.size() == 0) begin
                check("word_unexpected", bus.word_valid, 1'b0);
            end else begin
                got_word = exp_words.pop_front();
                check("word_data", bus.word_data, got_word.data);
                check("word_nsym", bus.word_nsym, got_word.nsym);
                check("word_last", bus.word_last, got_word.last);
            end
        end
    end

    task automatic drive_req(input logic [63:0] nonce, input logic [63:0] idx,
                             input logic [CNT_W-1:0] cnt);
        int c = 0;
        while (!bus.req_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("req_ready_before_req", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid       = 1'b1;
        bus.req_nonce       = nonce;
        bus.req_start_index = idx;
        bus.req_count       = cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Reference model: push expected PRF calls and packed words, then drive the request.
    task automatic send_req(input logic [63:0] nonce, input logic [63:0] idx,
                            input logic [CNT_W-1:0] cnt);
        logic [63:0] w  = '0;
        int          ns = 0;
        logic [63:0] ix;
        logic [4:0]  sym;
        for (int i = 0; i < int'(cnt); i++) begin
            ix  = idx + 64'(i);
            sym = ix[4:0] ^ nonce[4:0];
            exp_calls.push_back('{nonce: nonce, index: ix});
            w[ns*5 +: 5] = sym;
            ns++;
            if (ns == 12 || i == int'(cnt) - 1) begin
                exp_words.push_back('{data: w, nsym: 4'(ns), last: (i == int'(cnt) - 1)});
                w  = '0;
                ns = 0;
            end
        end
        drive_req(nonce, idx, cnt);
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        @(negedge clk);
        while ((bus.busy || exp_words.size() != 0) && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", bus.busy, 1'b0);
        check("words_outstanding", 64'(exp_words.size()), 64'd0);
        check("calls_outstanding", 64'(exp_calls.size()), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int lat;
        int s0;
        int w0;

        rst                 = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_nonce       = '0;
        bus.req_start_index = '0;
        bus.req_count       = '0;
        bus.word_ready      = 1'b1;
        stub_en             = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready",   bus.req_ready,   1'b1);
        check("rst_busy",        bus.busy,        1'b0);
        check("rst_word_valid",  bus.word_valid,  1'b0);
        check("rst_prf_start",   bus.prf_start,   1'b0);
        check("rst_timeout_err", bus.timeout_err, 1'b0);
        check("rst_word_data",   bus.word_data,   64'd0);
        check("rst_word_nsym",   bus.word_nsym,   4'd0);
        check("rst_word_last",   bus.word_last,   1'b0);

        // Single symbol
        send_req(64'd0, 64'd0, 16'd1);
        wait_idle(200);

        // One full word then a one-symbol tail
        send_req(64'd0, 64'd0, 16'd13);
        wait_idle(500);

        // Non-trivial nonce, three words (12 + 12 + 6)
        send_req(64'hA5A5_0000_1234_0013, 64'h10, 16'd30);
        wait_idle(1000);

        // Consumer stall on a full word
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        send_req(64'd3, 64'd100, 16'd12);
        c = 0;
        while (!bus.word_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("stall_word_valid", bus.word_valid, 1'b1);
        s0 = n_starts;
        repeat (20) begin
            @(negedge clk);
            check("stall_valid_held", bus.word_valid, 1'b1);
            check("stall_data_held",  bus.word_data,  exp_words[0].data);
        end
        check("stall_prf_starts", 64'(n_starts - s0), 64'd0);
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        wait_idle(100);

        // Index wrap at 2^64
        send_req(64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 16'd3);
        wait_idle(200);

        // Timeout: stub never answers
        stub_en = 1'b0;
        exp_calls.push_back('{nonce: 64'd0, index: 64'h55});
        exp_words.push_back('{data: 64'd0, nsym: 4'd0, last: 1'b1});
        drive_req(64'd0, 64'h55, 16'd5);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.prf_start && c < 20);
        check("tmo_prf_start", bus.prf_start, 1'b1);
        lat = 0;
        while (!bus.word_valid && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("tmo_latency",     64'(lat),        64'd4097);
        check("tmo_timeout_err", bus.timeout_err, 1'b1);
        wait_idle(100);
        check("tmo_err_sticky",  bus.timeout_err, 1'b1);
        stub_en = 1'b1;

        // Next accepted request clears timeout_err
        send_req(64'd1, 64'd7, 16'd2);
        check("tmo_err_cleared", bus.timeout_err, 1'b0);
        wait_idle(200);

        // Zero-count request: no PRF call, no word
        s0 = n_starts;
        w0 = n_words;
        send_req(64'd9, 64'd9, 16'd0);
        repeat (10) @(negedge clk);
        check("zero_req_ready", bus.req_ready, 1'b1);
        check("zero_busy",      bus.busy,      1'b0);
        check("zero_starts",    64'(n_starts - s0), 64'd0);
        check("zero_words",     64'(n_words - w0),  64'd0);

        // Reset during WAIT; the stub's late done must be ignored
        exp_calls.push_back('{nonce: 64'd2, index: 64'd40});
        drive_req(64'd2, 64'd40, 16'd4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        s0 = n_starts;
        repeat (8) @(negedge clk);
        check("abort_busy",       bus.busy,       1'b0);
        check("abort_word_valid", bus.word_valid, 1'b0);
        check("abort_word_nsym",  bus.word_nsym,  4'd0);
        check("abort_req_ready",  bus.req_ready,  1'b1);
        check("abort_starts",     64'(n_starts - s0), 64'd0);
        check("abort_calls",      64'(exp_calls.size()), 64'd0);

        // Recovery after abort
        send_req(64'hFF, 64'h20, 16'd5);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
